controlador_entrada: RTL and testbench
======================================

Name: controlador_entrada

Overview:
- Other end of the processor's IN syscall.
- The processor raises WAIT and stalls until an input value is supplied.
- This block answers that request. It debounces the DE2-115 confirm key (KEY, active-low), latches the 16 switches on a confirmed press, presents them as a 32-bit word, and pulses a release so the processor can write the value through its SwToReg path and resume.
- Sits in the top level between the board I/O and the processor.

Parameters:
- DEBOUNCE_CYCLES, 50000: consecutive stable samples required to accept a key level change (1 ms at 50 MHz).
- CNT_W, 16: debounce counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.
- SIGN_EXT, 0: 0 = zero-extend switches to 32 bits; 1 = sign-extend from switches[15].

Ports:
- clk, input, 1: single clock; all state updates on its rising edge.
- reset, input, 1: synchronous, active-high reset.
- wait_req, input, 1: processor WAIT; level, held high while the processor awaits input.
- botao, input, 1: raw confirm key; active-low (0 = pressed); asynchronous to clk.
- switches, input, 16: raw switch bank.
- dado_sw32, output, 32: latched switch word for the processor's register write.
- libera, output, 1: one-cycle pulse; input is valid and the processor may resume.
- aguardando, output, 1: high while a request is pending (drives an LED).

Behaviour:
- Synchronizer: two flops on botao. Both reset to 1 (released).
- Debouncer:
  - botao_db resets to 1.
  - The counter clears whenever the synchronized level equals botao_db.
  - Otherwise the counter increments, saturating (no wrap).
  - When the count reaches DEBOUNCE_CYCLES-1 while still differing, botao_db takes the new level and the counter clears.
  - Result: a glitch shorter than DEBOUNCE_CYCLES samples never changes botao_db.
- FSM states: OCIOSO, ARMA, PRESSIONA, LIBERA, CONCLUI. Reset state is OCIOSO.
- OCIOSO:
  - wait_req=1 → ARMA.
- ARMA (key must first be seen released; a key held from before the request is not accepted):
  - botao_db=1 → PRESSIONA.
- PRESSIONA:
  - botao_db=0 → LIBERA.
  - On that same edge, dado_sw32 loads the switches, extended per SIGN_EXT.
- LIBERA:
  - libera=1 for exactly this one cycle.
  - Always → CONCLUI.
- CONCLUI:
  - wait_req=0 → OCIOSO.
  - No re-arm while wait_req stays high, which prevents double acceptance.
- aguardando = 1 in ARMA and PRESSIONA; 0 in all other states.
- wait_req drops in ARMA or PRESSIONA (request withdrawn): → OCIOSO next edge; no libera; dado_sw32 unchanged.
- dado_sw32 is held between requests; switch changes after the latch have no effect.
- Latency:
  - Raw botao falling edge to botao_db low: 2 + DEBOUNCE_CYCLES edges, provided the level stays stable.
  - libera is high in the cycle after the edge where the FSM samples botao_db=0 in PRESSIONA.
- Reset (including mid-operation) forces on the next edge:
  - dado_sw32 = 0, libera = 0, aguardando = 0;
  - FSM in OCIOSO, counter cleared, botao_db and synchronizer = 1.
- Simultaneous events:
  - Reset has priority over every other event.
  - If wait_req falls in the same cycle the FSM is in PRESSIONA with botao_db=0, withdrawal wins: no latch, no libera.

Test Plan (DEBOUNCE_CYCLES=4, SIGN_EXT=0 unless noted):
- Basic request:
  - Stimulus: wait_req=1; switches=16'h00A5; botao held low from cycle 10 onward.
  - Required: exactly one libera pulse; dado_sw32=32'h000000A5 in the libera cycle; aguardando falls with libera; no second pulse while wait_req stays high.
- Held key:
  - Stimulus: botao already low when wait_req rises.
  - Required: no libera until botao goes high for ≥4 cycles and then low for ≥4 cycles.
- Glitch rejection:
  - Stimulus: botao low pulses of 1–3 cycles during PRESSIONA.
  - Required: botao_db stays 1, no libera, aguardando stays 1.
- Sign extension:
  - Stimulus: SIGN_EXT=1, switches=16'h8001, valid press.
  - Required: dado_sw32=32'hFFFF8001.
  - Same stimulus with SIGN_EXT=0 → 32'h00008001.
- Withdrawal and reset:
  - Stimulus A: wait_req drops during PRESSIONA.
  - Required A: FSM returns to OCIOSO, no libera, dado_sw32 keeps its prior value.
  - Stimulus B: reset asserted in LIBERA.
  - Required B: libera=0 and dado_sw32=0 on the next edge.
- Back-to-back:
  - Stimulus: two requests separated by a wait_req low cycle; switches 16'h0001 then 16'h0002.
  - Required: two libera pulses, latching 32'h1 then 32'h2.

Source files
------------

// File: rtl/controlador_entrada.sv
// Purpose: answers the processor's IN request by latching the switch bank on a debounced key press.
// Latency: libera one cycle after PRESSIONA sees botao_db low; key edge to botao_db is 2 + DEBOUNCE_CYCLES edges.
// Backpressure: the processor stalls on wait_req until libera; no re-arm until wait_req drops.
module controlador_entrada #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_W           = 16,
    parameter bit SIGN_EXT        = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wait_req,
    input  logic        botao,
    input  logic [15:0] switches,
    output logic [31:0] dado_sw32,
    output logic        libera,
    output logic        aguardando
);

    typedef enum logic [2:0] {
        OCIOSO    = 3'd0,
        ARMA      = 3'd1,
        PRESSIONA = 3'd2,
        LIBERA    = 3'd3,
        CONCLUI   = 3'd4
    } estado_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    logic             sync1_q, sync2_q;
    logic             botao_db_q, botao_db_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    estado_t          estado_q, estado_d;
    logic [31:0]      dado_q, dado_d;
    logic [31:0]      sw_ext;

    // Two-flop synchronizer for the asynchronous key; idles at released (1).
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= botao;
            sync2_q <= sync1_q;
        end
    end

    // Debounce: accept a new level only after it has differed for DEBOUNCE_CYCLES samples.
    always_comb begin
        botao_db_d = botao_db_q;
        cnt_d      = cnt_q;
        if (sync2_q == botao_db_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            botao_db_d = sync2_q;
            cnt_d      = '0;
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Debounce state registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            botao_db_q <= 1'b1;
            cnt_q      <= '0;
        end else begin
            botao_db_q <= botao_db_d;
            cnt_q      <= cnt_d;
        end
    end

    // Switch word as the processor sees it: zero- or sign-extended from bit 15.
    always_comb begin
        sw_ext = {16'h0000, switches};
        if (SIGN_EXT) begin
            sw_ext = {{16{switches[15]}}, switches};
        end
    end

    // Request FSM: wait for a release, then a press; withdrawal of wait_req aborts.
    always_comb begin
        estado_d = estado_q;
        dado_d   = dado_q;
        case (estado_q)
            OCIOSO: begin
                if (wait_req) estado_d = ARMA;
            end
            ARMA: begin
                if (!wait_req)      estado_d = OCIOSO;
                else if (botao_db_q) estado_d = PRESSIONA;
            end
            PRESSIONA: begin
                if (!wait_req) begin
                    estado_d = OCIOSO;
                end else if (!botao_db_q) begin
                    estado_d = LIBERA;
                    dado_d   = sw_ext;
                end
            end
            LIBERA: begin
                estado_d = CONCLUI;
            end
            CONCLUI: begin
                if (!wait_req) estado_d = OCIOSO;
            end
            default: begin
                estado_d = OCIOSO;
            end
        endcase
    end

    // FSM state and latched data word.
    always_ff @(posedge clk) begin
        if (reset) begin
            estado_q <= OCIOSO;
            dado_q   <= '0;
        end else begin
            estado_q <= estado_d;
            dado_q   <= dado_d;
        end
    end

    assign dado_sw32  = dado_q;
    assign libera     = (estado_q == LIBERA);
    assign aguardando = (estado_q == ARMA) || (estado_q == PRESSIONA);

endmodule

// File: tb/tb_controlador_entrada.sv
// Purpose: scoreboard bench for controlador_entrada, zero- and sign-extending instances in lockstep.
// Latency: expects libera 7 edges after a clean key press while in PRESSIONA (DEBOUNCE_CYCLES=4).
// Backpressure: wait_req is held by the bench to model the stalled processor.
module tb_controlador_entrada;

    logic        clk = 1'b0;
    logic        reset;
    logic        wait_req;
    logic        botao;
    logic [15:0] switches;
    logic [31:0] dado0, dado1;
    logic        lib0, lib1, ag0, ag1;

    int checks = 0;
    int errors = 0;
    int n_lib0 = 0;
    int n_lib1 = 0;
    logic [31:0] q0[$];
    logic [31:0] q1[$];

    always #5 clk = ~clk;

    controlador_entrada #(.DEBOUNCE_CYCLES(4), .CNT_W(4), .SIGN_EXT(1'b0)) dut0 (
        .clk(clk), .reset(reset), .wait_req(wait_req), .botao(botao), .switches(switches),
        .dado_sw32(dado0), .libera(lib0), .aguardando(ag0)
    );

    controlador_entrada #(.DEBOUNCE_CYCLES(4), .CNT_W(4), .SIGN_EXT(1'b1)) dut1 (
        .clk(clk), .reset(reset), .wait_req(wait_req), .botao(botao), .switches(switches),
        .dado_sw32(dado1), .libera(lib1), .aguardando(ag1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input logic [31:0] e0, input logic [31:0] e1);
        q0.push_back(e0);
        q1.push_back(e1);
    endtask

    task automatic wait_lib(input string tag);
        int start;
        int k;
        start = n_lib0;
        k = 0;
        while (n_lib0 == start && k < 30) begin
            step(1);
            k++;
        end
        check(tag, 32'(n_lib0 > start), 32'd1);
    endtask

    // Scoreboard: every libera pulse pops the expected word for that instance.
    initial begin
        forever begin
            @(negedge clk);
            if (lib0 === 1'b1) begin
                n_lib0++;
                if (q0.size() == 0) check("lib0_unexpected", 32'(lib0), 32'd0);
                else                check("dado0_at_libera", dado0, q0.pop_front());
                check("ag0_at_libera", 32'(ag0), 32'd0);
            end
            if (lib1 === 1'b1) begin
                n_lib1++;
                if (q1.size() == 0) check("lib1_unexpected", 32'(lib1), 32'd0);
                else                check("dado1_at_libera", dado1, q1.pop_front());
            end
        end
    end

    initial begin
        logic bad;
        reset    = 1'b1;
        wait_req = 1'b0;
        botao    = 1'b1;
        switches = 16'h0000;
        step(3);
        check("rst_dado0", dado0, 32'h0);
        check("rst_dado1", dado1, 32'h0);
        check("rst_libera", 32'(lib0), 32'd0);
        check("rst_aguardando", 32'(ag0), 32'd0);
        reset = 1'b0;
        step(2);

        // Basic request with exact latency from the key edge.
        switches = 16'h00A5;
        wait_req = 1'b1;
        step(1);
        check("basic_ag_arma", 32'(ag0), 32'd1);
        step(8);
        push(32'h000000A5, 32'h000000A5);
        botao = 1'b0;
        step(6);
        check("basic_lib_early", 32'(lib0), 32'd0);
        check("basic_ag_wait", 32'(ag0), 32'd1);
        step(1);
        check("basic_lib_lat", 32'(lib0), 32'd1);
        check("basic_dado", dado0, 32'h000000A5);
        step(1);
        check("basic_lib_one", 32'(lib0), 32'd0);
        check("basic_ag_after", 32'(ag0), 32'd0);
        botao = 1'b1;
        step(8);
        botao = 1'b0;
        step(12);
        check("basic_no_second", 32'(n_lib0), 32'd1);
        wait_req = 1'b0;
        botao    = 1'b1;
        step(8);

        // Key already held when the request arrives.
        botao = 1'b0;
        step(8);
        switches = 16'h1234;
        wait_req = 1'b1;
        step(20);
        check("held_no_lib", 32'(n_lib0), 32'd1);
        check("held_ag", 32'(ag0), 32'd1);
        push(32'h00001234, 32'h00001234);
        botao = 1'b1;
        step(8);
        botao = 1'b0;
        wait_lib("held_lib_tmo");
        wait_req = 1'b0;
        botao    = 1'b1;
        step(8);

        // Glitches of 1..3 cycles while in PRESSIONA.
        wait_req = 1'b1;
        step(3);
        bad = 1'b0;
        for (int len = 1; len <= 3; len++) begin
            botao = 1'b0;
            for (int i = 0; i < len; i++) begin
                step(1);
                bad = bad | ~ag0;
            end
            botao = 1'b1;
            for (int i = 0; i < 8; i++) begin
                step(1);
                bad = bad | ~ag0;
            end
        end
        check("glitch_ag_drop", 32'(bad), 32'd0);
        check("glitch_no_lib", 32'(n_lib0), 32'd2);

        // Withdrawal while in PRESSIONA.
        switches = 16'hBEEF;
        wait_req = 1'b0;
        step(1);
        check("wd_ag", 32'(ag0), 32'd0);
        step(3);
        check("wd_no_lib", 32'(n_lib0), 32'd2);
        check("wd_dado_kept", dado0, 32'h00001234);

        // Withdrawal in the same cycle the press is seen.
        wait_req = 1'b1;
        step(3);
        botao = 1'b0;
        step(6);
        wait_req = 1'b0;
        step(1);
        check("race_ag", 32'(ag0), 32'd0);
        check("race_lib", 32'(lib0), 32'd0);
        step(3);
        check("race_no_lib", 32'(n_lib0), 32'd2);
        check("race_dado_kept", dado0, 32'h00001234);
        botao = 1'b1;
        step(8);

        // Sign extension on the second instance; data held after latch.
        switches = 16'h8001;
        push(32'h00008001, 32'hFFFF8001);
        wait_req = 1'b1;
        step(3);
        botao = 1'b0;
        wait_lib("sx_lib_tmo");
        switches = 16'h7777;
        step(3);
        check("sx_hold0", dado0, 32'h00008001);
        check("sx_hold1", dado1, 32'hFFFF8001);
        wait_req = 1'b0;
        botao    = 1'b1;
        step(8);

        // Reset asserted during the LIBERA cycle.
        switches = 16'h00C3;
        push(32'h000000C3, 32'h000000C3);
        wait_req = 1'b1;
        step(3);
        botao = 1'b0;
        step(7);
        check("rl_in_libera", 32'(lib0), 32'd1);
        reset = 1'b1;
        step(1);
        check("rl_libera", 32'(lib0), 32'd0);
        check("rl_dado0", dado0, 32'h0);
        check("rl_dado1", dado1, 32'h0);
        check("rl_ag", 32'(ag0), 32'd0);
        reset    = 1'b0;
        wait_req = 1'b0;
        botao    = 1'b1;
        step(8);

        // Back-to-back requests separated by one wait_req low cycle.
        switches = 16'h0001;
        push(32'h00000001, 32'h00000001);
        wait_req = 1'b1;
        step(3);
        botao = 1'b0;
        wait_lib("b2b_first_tmo");
        botao    = 1'b1;
        wait_req = 1'b0;
        step(1);
        wait_req = 1'b1;
        switches = 16'h0002;
        push(32'h00000002, 32'h00000002);
        step(8);
        botao = 1'b0;
        wait_lib("b2b_second_tmo");
        wait_req = 1'b0;
        botao    = 1'b1;
        step(4);
        check("b2b_total", 32'(n_lib0), 32'd6);

        check("sb0_empty", 32'(q0.size()), 32'd0);
        check("sb1_empty", 32'(q1.size()), 32'd0);
        check("lib_count_match", 32'(n_lib1), 32'(n_lib0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
